// File: rtl/tp_mux_sched_if.sv
// Debug test-point bus bundle: group inputs, JTAG-sourced settings and the
// registered test-point outputs of tp_mux_sched.
interface tp_mux_sched_if #(
    parameter int NGRP    = 4,
    parameter int W       = 16,
    parameter int DWELL_W = 16
);
    logic [NGRP*W-1:0]  GRP_DATA;
    logic [1:0]         MODE;
    logic [2:0]         SEL_GRP;
    logic [DWELL_W-1:0] DWELL;
    logic [W-1:0]       TRIG_MASK;
    logic [W-1:0]       TRIG_VAL;
    logic               ARM;
    logic [W-1:0]       TP_OUT;
    logic [2:0]         TP_GRP;
    logic               GRP_CHG;
    logic               FROZEN;
    logic [7:0]         TRIG_CNT;

    modport master (
        output GRP_DATA, MODE, SEL_GRP, DWELL, TRIG_MASK, TRIG_VAL, ARM,
        input  TP_OUT, TP_GRP, GRP_CHG, FROZEN, TRIG_CNT
    );

    modport slave (
        input  GRP_DATA, MODE, SEL_GRP, DWELL, TRIG_MASK, TRIG_VAL, ARM,
        output TP_OUT, TP_GRP, GRP_CHG, FROZEN, TRIG_CNT
    );
endinterface

// File: rtl/tp_mux_sched.sv
// Test-point bus scheduler: grants one debug group to the 16-bit test-point
// bus in fixed, timed round-robin or trigger-freeze mode; all outputs registered.
module tp_mux_sched #(
    parameter int NGRP    = 4,
    parameter int W       = 16,
    parameter int DWELL_W = 16
) (
    input  logic           CLK,
    input  logic           RST_B,
    tp_mux_sched_if.slave  bus
);
    typedef enum logic [2:0] {
        S_OFF,
        S_FIXED,
        S_ROTATE,
        S_ARMED,
        S_FROZEN
    } state_t;

    localparam logic [3:0] NGRP_L   = 4'(NGRP);
    localparam logic [2:0] LAST_GRP = 3'(NGRP - 1);

    state_t             r_state;
    logic [W-1:0]       r_tp_out;
    logic [2:0]         r_tp_grp;
    logic               r_grp_chg;
    logic               r_frozen;
    logic [7:0]         r_trig_cnt;
    logic [DWELL_W-1:0] r_dwell;

    state_t             w_nxt_state;
    logic [W-1:0]       w_nxt_out;
    logic [2:0]         w_nxt_grp;
    logic [7:0]         w_nxt_cnt;
    logic [DWELL_W-1:0] w_nxt_dwell;
    logic [2:0]         w_sel;
    logic [2:0]         w_step_grp;
    logic [W-1:0]       w_sel_data;
    logic [DWELL_W-1:0] w_reload;
    logic               w_match;

    // Explicit mux avoids indexing a NGRP-entry bus with a wider 3-bit select.
    function automatic logic [W-1:0] pick(input logic [2:0] idx);
        logic [W-1:0] v;
        v = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (idx == 3'(g)) v = bus.GRP_DATA[g*W +: W];
        end
        return v;
    endfunction

    assign w_sel      = ({1'b0, bus.SEL_GRP} < NGRP_L) ? bus.SEL_GRP : 3'd0;
    assign w_sel_data = pick(w_sel);
    assign w_step_grp = (r_tp_grp == LAST_GRP) ? 3'd0 : r_tp_grp + 3'd1;
    assign w_reload   = (bus.DWELL == '0) ? '0 : bus.DWELL - DWELL_W'(1);
    assign w_match    = ((w_sel_data ^ bus.TRIG_VAL) & bus.TRIG_MASK) == '0;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_out   = r_tp_out;
        w_nxt_grp   = r_tp_grp;
        w_nxt_cnt   = r_trig_cnt;
        w_nxt_dwell = r_dwell;
        case (bus.MODE)
            2'd0: begin
                w_nxt_state = S_FIXED;
                w_nxt_grp   = w_sel;
                w_nxt_out   = w_sel_data;
            end
            2'd1: begin
                w_nxt_state = S_ROTATE;
                if (r_state != S_ROTATE) begin
                    w_nxt_grp   = 3'd0;
                    w_nxt_out   = pick(3'd0);
                    w_nxt_dwell = w_reload;
                end else if (r_dwell == '0) begin
                    w_nxt_grp   = w_step_grp;
                    w_nxt_out   = pick(w_step_grp);
                    w_nxt_dwell = w_reload;
                end else begin
                    w_nxt_out   = pick(r_tp_grp);
                    w_nxt_dwell = r_dwell - DWELL_W'(1);
                end
            end
            2'd2: begin
                if (r_state == S_FROZEN) begin
                    // Hold everything until an ARM pulse releases the freeze.
                    if (bus.ARM) begin
                        w_nxt_state = S_ARMED;
                        w_nxt_grp   = w_sel;
                        w_nxt_out   = w_sel_data;
                    end
                end else begin
                    w_nxt_state = S_ARMED;
                    w_nxt_grp   = w_sel;
                    w_nxt_out   = w_sel_data;
                    // ARM restarts arming and wins over a same-cycle match.
                    if (r_state == S_ARMED && !bus.ARM && w_match) begin
                        w_nxt_state = S_FROZEN;
                        w_nxt_cnt   = (r_trig_cnt == 8'hFF) ? r_trig_cnt
                                                            : r_trig_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_nxt_state = S_OFF;
                w_nxt_out   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_state    <= S_OFF;
            r_tp_out   <= '0;
            r_tp_grp   <= 3'd0;
            r_grp_chg  <= 1'b0;
            r_frozen   <= 1'b0;
            r_trig_cnt <= 8'd0;
            r_dwell    <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_tp_out   <= w_nxt_out;
            r_tp_grp   <= w_nxt_grp;
            r_grp_chg  <= (w_nxt_grp != r_tp_grp);
            r_frozen   <= (w_nxt_state == S_FROZEN);
            r_trig_cnt <= w_nxt_cnt;
            r_dwell    <= w_nxt_dwell;
        end
    end

    assign bus.TP_OUT   = r_tp_out;
    assign bus.TP_GRP   = r_tp_grp;
    assign bus.GRP_CHG  = r_grp_chg;
    assign bus.FROZEN   = r_frozen;
    assign bus.TRIG_CNT = r_trig_cnt;
endmodule

// File: doc/tp_mux_sched.md
Name: tp_mux_sched

Overview:
- Scheduler/arbiter for the FPGA debug test-point bank.
- Several debug groups request the single 16-bit test-point bus. The block grants one group at a time in one of three modes:
  - fixed: operator-selected group.
  - rotate: timed round-robin.
  - trigger-freeze: live view of one group, frozen on a pattern match.
- Sits between the debug signal groups and the test-point output drivers. Mode, group, dwell and trigger settings come from JTAG user registers.

Parameters:
- NGRP, 4, number of requesting debug groups (2..8).
- W, 16, test-point bus width per group.
- DWELL_W, 16, width of the rotate dwell counter.

Ports:
- CLK  input  1  system clock; all logic runs on its rising edge.
- RST_B  input  1  asynchronous active-low reset.
- GRP_DATA  input  NGRP*W  concatenated group buses; group g occupies bits [g*W+W-1 : g*W].
- MODE  input  2  0 = fixed, 1 = rotate, 2 = trigger-freeze, 3 = off (drive zeros).
- SEL_GRP  input  3  group used in fixed and trigger modes.
- DWELL  input  DWELL_W  cycles per group in rotate mode.
- TRIG_MASK  input  W  bits that take part in the trigger compare.
- TRIG_VAL  input  W  trigger compare value.
- ARM  input  1  single-cycle pulse that arms or re-arms the trigger.
- TP_OUT  output  W  registered data to the test-point drivers.
- TP_GRP  output  3  group currently driving TP_OUT.
- GRP_CHG  output  1  one-cycle pulse when TP_GRP changes.
- FROZEN  output  1  high while the output is frozen after a trigger.
- TRIG_CNT  output  8  number of triggers since reset; saturates at 255.

Behaviour:
- Reset (RST_B low, asynchronous): state OFF, TP_OUT = 0, TP_GRP = 0, GRP_CHG = 0, FROZEN = 0, TRIG_CNT = 0, dwell counter = 0. Release is synchronous to CLK.
- All outputs are registered. TP_OUT reflects the granted group's GRP_DATA from the previous cycle (latency 1).
- Group index: if SEL_GRP ≥ NGRP, group 0 is used.
- FSM states: OFF, FIXED, ROTATE, ARMED, FROZEN.
  - MODE is sampled every cycle. A MODE change moves the FSM next cycle to the entry state for the new mode: OFF, FIXED, ROTATE, or ARMED for mode 2. No ARM pulse is needed to enter ARMED on a mode change.
  - Leaving FROZEN because of a mode change clears FROZEN.
- OFF: TP_OUT = 0; TP_GRP holds its last value.
- FIXED: TP_GRP = SEL_GRP; TP_OUT = that group's data. A SEL_GRP change takes effect next cycle.
- ROTATE:
  - On entry, TP_GRP = 0 and the counter loads max(DWELL, 1) − 1.
  - The counter decrements each cycle. At 0, TP_GRP advances (NGRP−1 wraps to 0) and the counter reloads from the current DWELL.
  - DWELL = 0 is treated as 1: the group changes every cycle.
  - A DWELL change affects only the next reload.
- ARMED:
  - TP_GRP = SEL_GRP; TP_OUT follows live data.
  - Match condition: (group data & TRIG_MASK) == (TRIG_VAL & TRIG_MASK), evaluated on the unregistered group data.
  - On a match, TP_OUT latches the matching word, state → FROZEN, FROZEN = 1, TRIG_CNT increments (saturating).
  - TRIG_MASK = 0 matches on the first ARMED cycle.
- FROZEN:
  - TP_OUT, TP_GRP and TRIG_CNT hold.
  - An ARM pulse returns to ARMED. FROZEN drops the cycle after ARM is sampled, and live data resumes.
- ARM in ARMED: restarts arming. It has priority over a same-cycle match, so no freeze and no count occur that cycle. ARM outside modes ARMED/FROZEN is ignored.
- GRP_CHG: high for exactly one cycle whenever the registered TP_GRP differs from its previous value. This covers rotate steps, SEL_GRP changes and mode changes. It is never asserted in the first cycle after reset release unless TP_GRP actually changes.
- Reset asserted mid-operation: immediate return to reset values. No partial freeze and no count is retained.

Test Plan:
- Reset then MODE=0, SEL_GRP=2, group 2 = 16'hA5C3 → TP_OUT = 16'hA5C3 one cycle later; TP_GRP = 2; one GRP_CHG pulse.
- MODE=1, DWELL=3, NGRP=4 → TP_GRP sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 with a GRP_CHG pulse at each step. With DWELL=0 → the group changes every cycle.
- MODE=2, SEL_GRP=1, TRIG_MASK=16'h00FF, TRIG_VAL=16'h0042, group 1 counts up from 16'h1230 → freeze on 16'h1242; FROZEN = 1; TRIG_CNT = 1; TP_OUT holds 16'h1242 for 100 cycles.
- While FROZEN, pulse ARM → FROZEN = 0 next cycle and TP_OUT follows live data. ARM coincident with a match in ARMED → no freeze and TRIG_CNT unchanged.
- TRIG_MASK=0, then 300 repeated ARM/freeze cycles → TRIG_CNT saturates at 255.
- In ROTATE at TP_GRP=2, assert RST_B low asynchronously mid-cycle → TP_OUT = 0 and TP_GRP = 0 immediately. MODE=3 after release → TP_OUT stays 0. SEL_GRP=6 in MODE=0 → group 0 is selected.
